// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: assembles WIDTH-bit words from a strobed bit stream
// and presents them on a valid/ready port. Define SIPO_PARITY_EN for an even-parity frame bit.
module sipo_deserializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1,
`else
  localparam int FRAME = WIDTH,
`endif
  localparam int CW = $clog2(FRAME + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             shift,
  input  logic             clear,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    bit_count,
  output logic             overflow
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             take_s;

  // Shift-register contents with the current bit appended in the configured order
  always_comb begin
    if (MSB_FIRST) begin
      shifted_s = {sreg_r[WIDTH-2:0], serial_in};
    end else begin
      shifted_s = {serial_in, sreg_r[WIDTH-1:1]};
    end
  end

  // Completion on the last bit of a frame; the word is taken unless a pending one blocks it
  always_comb begin
    complete_s = shift && (bit_count == LAST);
    take_s     = complete_s && (!out_valid || out_ready);
`ifdef SIPO_PARITY_EN
    // the last frame bit is parity, so the data word is already fully shifted in
    word_s     = sreg_r;
`else
    word_s     = shifted_s;
`endif
  end

  // Frame assembly, output word register, handshake and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      sreg_r       <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overflow     <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else if (clear) begin
      sreg_r    <= '0;
      bit_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (shift) begin
        if (complete_s) begin
          bit_count <= '0;
          sreg_r    <= '0;
        end else begin
          bit_count <= bit_count + CW'(1);
          sreg_r    <= shifted_s;
        end
      end
      if (take_s) begin
        parallel_out <= word_s;
        out_valid    <= 1'b1;
`ifdef SIPO_PARITY_EN
        parity_err   <= (^sreg_r) ^ serial_in;
`endif
      end else if (complete_s) begin
        overflow <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: vector table, directed corner cases and
// randomized traffic against a queue-based reference model (both bit orders instantiated).
module tb_sipo_deserializer;
  localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  logic clk = 1'b0;
  logic reset, serial_in, shift, clear, out_ready;
  logic [WIDTH-1:0] po_m, po_l;
  logic ov_m, ov_l, of_m, of_l;
  logic [CW-1:0] bc_m, bc_l;
`ifdef SIPO_PARITY_EN
  logic pe_m, pe_l;
`endif

  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift(shift), .clear(clear),
    .parallel_out(po_m), .out_valid(ov_m), .out_ready(out_ready), .bit_count(bc_m),
    .overflow(of_m)
`ifdef SIPO_PARITY_EN
    , .parity_err(pe_m)
`endif
  );

  sipo_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .serial_in(serial_in), .shift(shift), .clear(clear),
    .parallel_out(po_l), .out_valid(ov_l), .out_ready(out_ready), .bit_count(bc_l),
    .overflow(of_l)
`ifdef SIPO_PARITY_EN
    , .parity_err(pe_l)
`endif
  );

  // Reference model: bits of the current frame in arrival order, plus the delivered word
  bit q[$];
  logic m_valid = 1'b0;
  logic m_ovf = 1'b0;
  logic m_perr = 1'b0;
  logic [WIDTH-1:0] m_word_m = '0;
  logic [WIDTH-1:0] m_word_l = '0;

  task automatic model_step(input logic r, input logic c, input logic s, input logic d,
                            input logic rd);
    logic done;
    logic [WIDTH-1:0] wm, wl;
    logic p;
    done = 1'b0;
    wm = '0;
    wl = '0;
    p = 1'b0;
    if (!r) begin
      q.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
      m_word_m = '0; m_word_l = '0;
    end else if (c) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (s) begin
        q.push_back(d);
        if (q.size() == FRAME) begin
          done = 1'b1;
          for (int i = 0; i < WIDTH; i++) begin
            wm = WIDTH'(wm * 2 + WIDTH'(q[i]));
            wl[i] = q[i];
          end
          for (int i = 0; i < FRAME; i++) p = p ^ q[i];
          q.delete();
        end
      end
      if (done && (!m_valid || rd)) begin
        m_valid = 1'b1; m_word_m = wm; m_word_l = wl; m_perr = p;
      end else if (done) begin
        m_ovf = 1'b1;
      end else if (rd) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick(input logic r, input logic c, input logic s, input logic d,
                      input logic rd);
    reset = r; clear = c; shift = s; serial_in = d; out_ready = rd;
    @(posedge clk);
    model_step(r, c, s, d, rd);
    #1;
  endtask

  // Shift one word MSB-first on consecutive cycles; out_ready only on the last bit if asked
  task automatic send(input logic [7:0] w, input logic rdy_last);
    for (int i = 7; i >= 0; i--) tick(1'b1, 1'b0, 1'b1, w[i], (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic check_model();
    check("rand_valid_m", 32'(ov_m), 32'(m_valid));
    check("rand_valid_l", 32'(ov_l), 32'(m_valid));
    check("rand_word_m", 32'(po_m), 32'(m_word_m));
    check("rand_word_l", 32'(po_l), 32'(m_word_l));
    check("rand_bitcount", 32'(bc_m), 32'(q.size()));
    check("rand_overflow", 32'(of_m), 32'(m_ovf));
`ifdef SIPO_PARITY_EN
    if (m_valid) check("rand_parity_err", 32'(pe_m), 32'(m_perr));
`endif
  endtask

  typedef struct {
    logic rst, clr, sh, sin, rdy;
    logic ev;
    logic [7:0] ew, ewl;
    logic [CW-1:0] ebc;
    logic eovf;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic clr, input logic sh,
                              input logic sin, input logic rdy, input logic ev,
                              input logic [7:0] ew, input logic [7:0] ewl,
                              input int ebc, input logic eovf);
    vec_t v;
    v.rst = rst; v.clr = clr; v.sh = sh; v.sin = sin; v.rdy = rdy;
    v.ev = ev; v.ew = ew; v.ewl = ewl; v.ebc = CW'(ebc); v.eovf = eovf;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    logic [7:0] pat;
    logic r, c, s, rd;

    // Vector table: reset, idle, 0xA5 word, hold, accept, then 1,1,0,0,0,0,0,0
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0));
`ifndef SIPO_PARITY_EN
    pat = 8'hA5;
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1, 0, 1, pat[7-i], 0, 0, 8'h00, 8'h00, i + 1, 0));
    tbl.push_back(mk(1, 0, 1, pat[0], 0, 1, 8'hA5, 8'hA5, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 1, 8'hA5, 8'hA5, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 0, 8'hA5, 8'hA5, 0, 0));
    pat = 8'hC0;
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(1, 0, 1, pat[7-i], 0, 0, 8'hA5, 8'hA5, i + 1, 0));
    tbl.push_back(mk(1, 0, 1, pat[0], 0, 1, 8'hC0, 8'h03, 0, 0));
`endif

    foreach (tbl[i]) begin
      tick(tbl[i].rst, tbl[i].clr, tbl[i].sh, tbl[i].sin, tbl[i].rdy);
      check("tbl_valid_m", 32'(ov_m), 32'(tbl[i].ev));
      check("tbl_valid_l", 32'(ov_l), 32'(tbl[i].ev));
      check("tbl_word_m", 32'(po_m), 32'(tbl[i].ew));
      check("tbl_word_l", 32'(po_l), 32'(tbl[i].ewl));
      check("tbl_bitcount", 32'(bc_m), 32'(tbl[i].ebc));
      check("tbl_overflow", 32'(of_m), 32'(tbl[i].eovf));
    end

`ifndef SIPO_PARITY_EN
    tick(1, 0, 0, 0, 1);
    check("accept_valid", 32'(ov_m), 32'd0);

    // Back-to-back words with no reader: second word dropped, overflow sticky until clear
    send(8'h3C, 1'b0);
    check("b2b_first_valid", 32'(ov_m), 32'd1);
    check("b2b_first_word", 32'(po_m), 32'h3C);
    send(8'hC3, 1'b0);
    check("b2b_word_kept", 32'(po_m), 32'h3C);
    check("b2b_overflow", 32'(of_m), 32'd1);
    check("b2b_bitcount", 32'(bc_m), 32'd0);
    tick(1, 1, 0, 0, 0);
    check("clear_overflow", 32'(of_m), 32'd0);
    check("clear_keeps_valid", 32'(ov_m), 32'd1);
    check("clear_keeps_word", 32'(po_m), 32'h3C);

    // Accept and completion in the same cycle: replacement, no overflow
    send(8'h5A, 1'b1);
    check("simul_valid", 32'(ov_m), 32'd1);
    check("simul_word", 32'(po_m), 32'h5A);
    check("simul_overflow", 32'(of_m), 32'd0);
    tick(1, 0, 0, 0, 1);

    // Abort mid-word by clear, then by reset
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 1, 0);
    check("abort_partial", 32'(bc_m), 32'd3);
    tick(1, 1, 1, 1, 0);
    check("abort_clear_bc", 32'(bc_m), 32'd0);
    send(8'h81, 1'b0);
    check("abort_clear_word", 32'(po_m), 32'h81);
    check("abort_clear_valid", 32'(ov_m), 32'd1);
    tick(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 1, 0, 0);
    tick(0, 0, 1, 1, 0);
    check("abort_reset_bc", 32'(bc_m), 32'd0);
    send(8'h81, 1'b0);
    check("abort_reset_word", 32'(po_m), 32'h81);
    check("abort_reset_bitcount", 32'(bc_m), 32'd0);
    tick(1, 0, 0, 0, 1);
`else
    // Parity frames: the word is delivered regardless of parity_err
    send(8'hA5, 1'b0);
    check("par_no_early_valid", 32'(ov_m), 32'd0);
    check("par_bitcount", 32'(bc_m), 32'd8);
    tick(1, 0, 1, 0, 0);
    check("par_ok_valid", 32'(ov_m), 32'd1);
    check("par_ok_word", 32'(po_m), 32'hA5);
    check("par_ok_err", 32'(pe_m), 32'd0);
    tick(1, 0, 0, 0, 1);
    send(8'hA5, 1'b0);
    tick(1, 0, 1, 1, 0);
    check("par_bad_valid", 32'(ov_m), 32'd1);
    check("par_bad_word", 32'(po_m), 32'hA5);
    check("par_bad_err", 32'(pe_m), 32'd1);
    tick(1, 0, 0, 0, 1);
`endif

    // Randomized traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 199) != 0);
      c  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 9) < 7);
      rd = c ? 1'b0 : ($urandom_range(0, 2) == 0);
      tick(r, c, s, 1'($urandom), rd);
      check_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out receiver for the shift-register serial link. It consumes the one-bit stream that an upstream SISO/PISO stage emits on its serial output, qualified by the same shift strobe. It assembles WIDTH-bit words and presents each completed word on a valid/ready parallel port. It sits at the receive end of the serial link and feeds downstream register or FIFO logic.

Parameters:
WIDTH, 8, data bits per word (legal range 2..32).
MSB_FIRST, 1, 1 = first received bit lands in parallel_out[WIDTH-1]; 0 = first received bit lands in parallel_out[0].

Ports:
clk  input  1  clock; all logic on the rising edge.
reset  input  1  synchronous, active-low reset: 0 at a rising clk edge resets the block.
serial_in  input  1  serial data bit; sampled only when shift=1.
shift  input  1  bit strobe; 1 = take serial_in this cycle.
clear  input  1  synchronous abort; discards any partial word and clears overflow.
parallel_out  output  WIDTH  last completed word.
out_valid  output  1  parallel_out holds an unconsumed word.
out_ready  input  1  downstream accepts the word when out_valid&&out_ready.
bit_count  output  clog2(WIDTH+1)  bits collected in the current partial word.
overflow  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (reset=0 at posedge): shift register=0, bit_count=0, parallel_out=0, out_valid=0, overflow=0. Reset has priority over every other input.
- clear=1 (reset=1): bit_count=0, shift register=0, overflow=0. parallel_out and out_valid are untouched, so a pending word survives. clear has priority over shift in the same cycle; that bit is discarded.
- Shift, MSB_FIRST=1: sreg <= {sreg[WIDTH-2:0], serial_in}.
- Shift, MSB_FIRST=0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
- Each shift increments bit_count.
- Word completion: a shift cycle with bit_count==WIDTH-1.
  - Same edge: bit_count wraps to 0.
  - The assembled word, including the current bit, goes to parallel_out, and out_valid=1 on the next cycle (one-cycle latency from the last bit's edge).
- Handshake:
  - out_valid stays high, and parallel_out stays stable, until a cycle with out_ready=1.
  - After that cycle out_valid=0, unless a new word completes in that same cycle.
  - out_ready while out_valid=0 has no effect.
- Completion while out_valid=1:
  - out_ready=1 in the same cycle: the new word replaces the old one and out_valid stays 1. No overflow.
  - out_ready=0: the new word is dropped, parallel_out keeps the old word, and overflow<=1.
- overflow stays set until reset or clear.
- shift=0 cycles hold all state; gaps between bits of any length are legal.
- Back-to-back words (shift held high) are supported at one bit per cycle with no idle cycle between words.

Optional Feature:
Macro SIPO_PARITY_EN.
- Defined:
  - A frame is WIDTH data bits followed by one even-parity bit, also strobed by shift.
  - bit_count counts 0..WIDTH and has width clog2(WIDTH+2).
  - Completion is the shift with bit_count==WIDTH, i.e. on the parity bit.
  - Extra output parity_err (1 bit): loaded together with parallel_out, equal to XOR of the WIDTH data bits and the parity bit. Valid only while out_valid=1; reset value 0.
  - The word is delivered even when parity_err=1.
  - A word dropped on overflow does not update parity_err.
- Undefined: no parity bit, no parity_err port, behaviour exactly as above.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then reset=1 with shift=0 for 10 cycles -> parallel_out=0x00, out_valid=0, bit_count=0, overflow=0 throughout.
- Basic word, WIDTH=8, MSB_FIRST=1: shift in 1,0,1,0,0,1,0,1 on 8 consecutive cycles, out_ready=0 -> out_valid=1 one cycle after the 8th bit, parallel_out=0xA5, held stable for 5 further cycles.
- Handshake: then assert out_ready for one cycle -> out_valid=0 next cycle.
- Bit order, MSB_FIRST=0: the same 8-bit sequence -> parallel_out=0xA5 bit-reversed = 0xA5 (palindrome). Repeat with 1,1,0,0,0,0,0,0 -> 0x03.
- Back-to-back with overflow: shift continuously for 16 bits (0x3C then 0xC3), out_ready=0 -> parallel_out stays 0x3C, overflow=1 after the 16th bit. Then clear=1 -> overflow=0 and out_valid still 1.
- Simultaneous accept: a word pending, out_ready=1 in the same cycle the next word (0x5A) completes -> out_valid stays 1, parallel_out=0x5A, overflow=0.
- Abort mid-word: after 3 bits pulse clear (or drive reset=0), then shift 8 bits of 0x81 -> bit_count returns to 0 on the abort, and the delivered word is 0x81 with no leftover bits.
- Parity build (SIPO_PARITY_EN): 0xA5 + parity 0 -> parity_err=0; 0xA5 + parity 1 -> parity_err=1, word still delivered.
